uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: two-flop synchronized rx, mid-bit sampling FSM, valid/ready output buffer.
// Optional even-parity bit is enabled by defining UART_RX_PARITY_EN.
//
// state     | meaning
// IDLE      | line idle, waiting for a low level
// START     | confirming the start bit at its midpoint
// DATA      | sampling DATA_BITS bits, LSB first
// PARITY    | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP      | sampling the stop bit, deliver or flag framing error
// WAIT_HIGH | line held low after a bad stop, wait for it to release
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t               state_q;
    logic                 rx_meta_q;
    logic                 rx_sync_q;
    logic [CW-1:0]        cyc_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    logic bit_tick;
    logic par_ok;
    logic deliver_d;

    assign bit_tick = (cyc_cnt_q == CNT_LAST);

`ifdef UART_RX_PARITY_EN
    logic par_bit_q;
    logic parity_err_q;
    assign par_ok     = ((^shift_q) == par_bit_q);
    assign parity_err = parity_err_q;
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    // A word is handed over only when the stop bit is high and parity (if any) agrees.
    assign deliver_d = (state_q == STOP) && bit_tick && rx_sync_q && par_ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            cyc_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif

            // Acceptance in the delivery cycle frees the buffer, so no overrun then.
            if (deliver_d) begin
                if (!rx_valid_q || rx_ready) begin
                    rx_data_q  <= shift_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    cyc_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    if (!rx_sync_q) state_q <= START;
                end
                START: begin
                    if (cyc_cnt_q == CNT_HALF) begin
                        cyc_cnt_q <= '0;
                        state_q   <= rx_sync_q ? IDLE : DATA;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        cyc_cnt_q <= '0;
                        shift_q   <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        cyc_cnt_q <= '0;
                        par_bit_q <= rx_sync_q;
                        state_q   <= STOP;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_tick) begin
                        cyc_cnt_q <= '0;
                        if (!rx_sync_q) frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= !par_ok;
`endif
                        state_q <= rx_sync_q ? IDLE : WAIT_HIGH;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_sync_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frame-level reference model feeds expected words and
// error pulses into queues; an independent monitor pops them as the DUT presents them.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = DB + 3;
`else
    localparam int FRAME_BITS = DB + 2;
`endif
    // Clock edges from start-bit launch to the edge that delivers the word.
    localparam int DELIV = CPB / 2 + 4 + CPB * (FRAME_BITS - 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx = 1'b1;
    logic          rx_ready = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun;
    logic          parity_err;

    int errors = 0;
    int checks = 0;
    bit done = 1'b0;

    typedef enum {E_FERR, E_PERR, E_OVR} evt_t;
    logic [DB-1:0] data_q[$];
    evt_t          err_q[$];
    bit            held = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endfunction

    // Frame-level expectation: bad stop -> frame error, bad parity -> parity error,
    // otherwise a word, which overruns if the previous word is still unclaimed.
    function automatic void model_frame(logic [DB-1:0] d, bit stop, bit par, bit ready_at_end);
        bit par_good;
        par_good = ((^d) == par);
        if (!stop) err_q.push_back(E_FERR);
        if (!par_good) err_q.push_back(E_PERR);
        if (stop && par_good) begin
            if (held && !ready_at_end) begin
                err_q.push_back(E_OVR);
            end else begin
                data_q.push_back(d);
                held = !ready_at_end;
            end
        end
    endfunction

    task automatic send_bit(input bit b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_raw(input logic [DB-1:0] d, input bit stop, input bit par, input bit rae);
        model_frame(d, stop, par, rae);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
    endtask

    task automatic send_good(input logic [DB-1:0] d, input bit rae);
        send_raw(d, 1'b1, ^d, rae);
    endtask

    function automatic void pop_err(evt_t exp, string name);
        evt_t e;
        checks++;
        if (err_q.size() == 0) begin
            errors++;
            $display("FAIL %s got=pulse expected=none", name);
        end else begin
            e = err_q.pop_front();
            if (e != exp) begin
                errors++;
                $display("FAIL %s got=%s expected=%s", name, exp.name(), e.name());
            end
        end
    endfunction

    function automatic void pop_data();
        logic [DB-1:0] d;
        checks++;
        if (data_q.size() == 0) begin
            errors++;
            $display("FAIL rx_word got=%0h expected=no_word", rx_data);
        end else begin
            d = data_q.pop_front();
            if (rx_data !== d) begin
                errors++;
                $display("FAIL rx_word got=%0h expected=%0h", rx_data, d);
            end
        end
    endfunction

    logic [DB-1:0] prev_data = '0;
    bit            prev_hold = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_hold = 1'b0;
        end else if (!done) begin
            if (frame_err)  pop_err(E_FERR, "frame_err");
            if (parity_err) pop_err(E_PERR, "parity_err");
            if (overrun)    pop_err(E_OVR, "overrun");
            if (rx_valid && rx_ready) pop_data();
            if (prev_hold) begin
                check("hold_valid", 32'(rx_valid), 32'd1);
                check("hold_data", 32'(rx_data), 32'(prev_data));
            end
            prev_hold = rx_valid && !rx_ready;
            prev_data = rx_data;
        end
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DB-1:0] d;
        bit            stop;
        bit            par;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle_bits(2);

        send_good(8'hA5, 1'b1);
        idle_bits(2);

        // Short low glitch must be rejected at the start-bit midpoint.
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        idle_bits(2);
        check("glitch_no_valid", 32'(rx_valid), 32'd0);

        d = 8'h3C;
        send_raw(d, 1'b0, ^d, 1'b1);
        repeat (40 * CPB) @(posedge clk);
        #1;
        idle_bits(2);
        send_good(8'h81, 1'b1);
        idle_bits(2);

        rx_ready = 1'b0;
        send_good(8'h11, 1'b0);
        idle_bits(1);
        send_good(8'h22, 1'b0);
        idle_bits(1);
        fork
            send_good(8'h33, 1'b1);
            begin
                repeat (DELIV - 1) @(posedge clk);
                #1 rx_ready = 1'b1;
            end
        join
        idle_bits(2);
        check("buffer_drained", 32'(data_q.size()), 32'd0);

        // Abandon 0x5A partway through its data bits.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_rx_valid", 32'(rx_valid), 32'd0);
        check("midrst_rx_data", 32'(rx_data), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle_bits(2);
        send_good(8'h96, 1'b1);
        idle_bits(2);

`ifdef UART_RX_PARITY_EN
        send_raw(8'h07, 1'b1, 1'b0, 1'b1);
        idle_bits(1);
        send_raw(8'h07, 1'b1, 1'b1, 1'b1);
        idle_bits(1);
`endif

        for (int n = 0; n < 24; n++) begin
            d    = DB'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            par  = ^d;
`ifdef UART_RX_PARITY_EN
            if ($urandom_range(0, 7) == 0) par = ~par;
`endif
            send_raw(d, stop, par, 1'b1);
            if (!stop) idle_bits(1);
            else idle_bits($urandom_range(0, 2));
        end
        idle_bits(3);

        check("words_left", 32'(data_q.size()), 32'd0);
        check("errs_left", 32'(err_q.size()), 32'd0);
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
